vga_stream_core: RTL and testbench
==================================

# vga_stream_core

Parametrised successor to the fixed-mode VGA core. It generates VGA sync and blanking for any resolution and sync polarity, issues frame-buffer read pointers a configurable number of cycles ahead of display, and aligns the returned pixel data with sync. It also has built-in test-pattern modes. It sits between the pixel-clock PLL/cache and the VGA pins, and replaces the hard-coded timing core in the streamer top level.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 72, horizontal sync width
- H_BP, 128, horizontal back porch
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1 / V_SYNC, 2 / V_BP, 22, vertical porches and sync (lines)
- H_POL, 1 / V_POL, 1, sync active level (1 = active-high)
- COLOR_BITS, 4, bits per colour channel
- FETCH_LAT, 2, cycles from read pointer issue to valid `pixstream`; legal range 1..8

Ports:
- clk  in  1  pixel clock (36 MHz for the defaults)
- reset  in  1  synchronous, active-low reset
- mode  in  2  0 = stream, 1 = colour bars, 2 = grid, 3 = black
- pixstream  in  3*COLOR_BITS  pixel data, packed {r,g,b} with MSB first
- hread_ptr  out  11  column of the requested pixel
- vread_ptr  out  11  row of the requested pixel
- read_en  out  1  high when the requested pixel is in the active area
- h_sync, v_sync  out  1  sync outputs, polarity set by H_POL / V_POL
- r, g, b  out  COLOR_BITS each  colour outputs
- drawing_pixels  out  1  display enable, aligned with r/g/b
- frame_start  out  1  one-cycle pulse aligned with the first active pixel of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the vertical equivalent. Defaults give 1024×625.
- Horizontal counter `h` runs 0..H_TOTAL-1 and wraps to 0. At each wrap the vertical counter `v` increments, and it wraps 0..V_TOTAL-1.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- h_sync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. v_sync uses the same rule on `v`. Both are evaluated at counter stage.
- Counter stage: hread_ptr=h, vread_ptr=v, read_en=active. These outputs are combinational from the counters.
- Delay line of depth FETCH_LAT carries {active, hsync, vsync, h, v, first-pixel flag} from counter stage. The output register then samples the delayed set together with `pixstream` (or pattern data).
- Output colour while drawing_pixels is low: all zero.
- Modes:
  - 0: r/g/b = pixstream fields.
  - 1: 8 vertical bars, each BAR_W = H_ACTIVE/8 pixels wide (integer division). Bar index i = min(h/BAR_W, 7), tracked with a bar counter, not a divider. Colour code c = 7-i with bit2=r, bit1=g, bit0=b. A set bit drives its channel to all ones.
  - 2: white where h[4:0]==0 or v[4:0]==0, black elsewhere.
  - 3: black.
- `mode` is latched only when the counter stage is at h=0, v=0, so a change never tears a frame. The reset value of the latched mode is 0.
- frame_start is high on the output cycle of pixel (0,0).

## Timing
- Latency from counter value to pins is FETCH_LAT+1 cycles. Sync, enable and colour are always mutually aligned.
- pixstream is sampled exactly FETCH_LAT cycles after the pointer that addressed it. The source must honour this fixed latency; there is no backpressure.
- During reset (reset=0 at a clk edge):
  - h=v=0 and the delay line is cleared to inactive.
  - h_sync=!H_POL, v_sync=!V_POL, r=g=b=0, drawing_pixels=0, frame_start=0.
  - read_en reflects counter (0,0), so it is 1.
- Reset mid-line takes effect at the next edge. The first post-reset output pixel (0,0) appears FETCH_LAT+1 cycles after reset releases, with frame_start=1.
- At wrap boundaries (h=H_TOTAL-1 → 0 and v=V_TOTAL-1 → 0) there are no idle or duplicated cycles.

## Test plan
- Reset: hold reset=0 for 5 cycles → sync outputs at their inactive level, rgb=0, drawing_pixels=0, hread_ptr=0, vread_ptr=0. Release reset → frame_start pulses exactly 3 cycles later (defaults).
- Horizontal timing (defaults): h_sync high for exactly 72 cycles. Its rising edge comes 824 cycles after the first drawing_pixels of the line. Line period = 1024 cycles.
- Vertical timing: v_sync high for exactly 2 lines. Frame period = 640,000 cycles. Exactly 600 lines carry 800 enabled pixels each.
- Fetch alignment: FETCH_LAT=3 with a model returning pixstream={hread_ptr[3:0], vread_ptr[3:0], 4'h5} three cycles late → output at pixel (h,v) equals {h[3:0], v[3:0], 5} everywhere in the active region, and 0 in blanking.
- Mode switch: set mode=1 mid-frame → remainder of the frame is still stream data. The next frame starts with bar 0 = 0xF/0xF/0xF. Pixel 100 = r F, g F, b 0 (bar 1). Pixel 799 = 0/0/0.
- Reset mid-frame at h=400, v=300 → counters restart at (0,0). There is no partial sync pulse longer than its spec width, and normal timing resumes.

Source files
------------

// File: rtl/vga_stream_core.sv
// vga_stream_core
//   Parametrised VGA timing generator with fixed-latency frame-buffer fetch.
//   A counter stage produces h/v, sync and active flags and issues read
//   pointers. A FETCH_LAT-deep delay line carries that state until the
//   addressed pixel returns on pixstream. An output register then drives
//   sync, enable and colour together. Built-in test patterns can replace
//   the streamed data.
//
// Ports
//   clk            pixel clock
//   reset          synchronous, active-low
//   mode[1:0]      0 stream, 1 colour bars, 2 grid, 3 black (latched per frame)
//   pixstream      returned pixel {r,g,b}, valid FETCH_LAT cycles after its pointer
//   hread_ptr      column being requested (counter stage, combinational)
//   vread_ptr      row being requested (counter stage, combinational)
//   read_en        requested pixel lies in the active area
//   h_sync/v_sync  sync outputs, active level set by H_POL / V_POL
//   r, g, b        colour outputs, zero outside the active area
//   drawing_pixels display enable, aligned with r/g/b
//   frame_start    one-cycle pulse on the output cycle of pixel (0,0)
//
// FETCH_LAT must lie in 1..8. Totals must fit the 11-bit counters.

module vga_stream_core #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 72,
  parameter int H_BP       = 128,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 22,
  parameter int H_POL      = 1,
  parameter int V_POL      = 1,
  parameter int COLOR_BITS = 4,
  parameter int FETCH_LAT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] pixstream,
  output logic [10:0]             hread_ptr,
  output logic [10:0]             vread_ptr,
  output logic                    read_en,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    drawing_pixels,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam logic        H_ON     = (H_POL != 0);
  localparam logic        V_ON     = (V_POL != 0);

  // Everything the output stage needs about one pixel. The grid test and the
  // bar colour are resolved at the counter stage so only a few bits travel
  // down the delay line instead of the full coordinates.
  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic       first;
    logic       grid;
    logic [2:0] bar_code;
    logic [1:0] mode;
  } beat_t;

  // ---------------------------------------------------------------- counters
  logic [10:0] h_q, h_d, v_q, v_d;
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  mode_q, mode_d;
  logic        at_origin, cnt_active, cnt_hs, cnt_vs;

  always_comb begin
    at_origin  = (h_q == 11'd0) && (v_q == 11'd0);
    cnt_active = (h_q < H_ACT) && (v_q < V_ACT);
    cnt_hs     = (h_q >= HS_BEG) && (h_q < HS_END);
    cnt_vs     = (v_q >= VS_BEG) && (v_q < VS_END);

    // The mode seen at (0,0) applies to the whole frame, including (0,0).
    mode_d = at_origin ? mode : mode_q;

    h_d       = h_q + 11'd1;
    v_d       = v_q;
    bar_cnt_d = bar_cnt_q + 11'd1;
    bar_idx_d = bar_idx_q;
    if (h_q == H_LAST) begin
      h_d       = 11'd0;
      bar_cnt_d = 11'd0;
      bar_idx_d = 3'd0;
      v_d       = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
    end else if ((bar_cnt_q == BAR_LAST) && (bar_idx_q != 3'd7)) begin
      // Bar index saturates at 7 so leftover pixels of a width that is not a
      // multiple of 8 stay in the last bar.
      bar_cnt_d = 11'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q       <= 11'd0;
      v_q       <= 11'd0;
      bar_cnt_q <= 11'd0;
      bar_idx_q <= 3'd0;
      mode_q    <= 2'd0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      mode_q    <= mode_d;
    end
  end

  assign hread_ptr = h_q;
  assign vread_ptr = v_q;
  assign read_en   = cnt_active;

  // -------------------------------------------------------------- delay line
  beat_t cnt_beat;
  beat_t dl_q [FETCH_LAT];
  beat_t dl_d [FETCH_LAT];

  always_comb begin
    cnt_beat          = '0;
    cnt_beat.active   = cnt_active;
    cnt_beat.hs       = cnt_hs;
    cnt_beat.vs       = cnt_vs;
    cnt_beat.first    = cnt_active && at_origin;
    cnt_beat.grid     = (h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0);
    cnt_beat.bar_code = 3'd7 - bar_idx_q;
    cnt_beat.mode     = mode_d;
  end

  always_comb begin
    dl_d[0] = cnt_beat;
    for (int i = 1; i < FETCH_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_LAT; i++) begin
      if (!reset) dl_q[i] <= '0;
      else        dl_q[i] <= dl_d[i];
    end
  end

  // ------------------------------------------------------------ output stage
  beat_t                 tail;
  logic [COLOR_BITS-1:0] pat_r, pat_g, pat_b;
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic                  de_q, de_d, fs_q, fs_d;

  assign tail = dl_q[FETCH_LAT-1];

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (tail.mode)
      2'd0: begin
        pat_r = pixstream[3*COLOR_BITS-1 -: COLOR_BITS];
        pat_g = pixstream[2*COLOR_BITS-1 -: COLOR_BITS];
        pat_b = pixstream[COLOR_BITS-1:0];
      end
      2'd1: begin
        pat_r = {COLOR_BITS{tail.bar_code[2]}};
        pat_g = {COLOR_BITS{tail.bar_code[1]}};
        pat_b = {COLOR_BITS{tail.bar_code[0]}};
      end
      2'd2: begin
        pat_r = {COLOR_BITS{tail.grid}};
        pat_g = {COLOR_BITS{tail.grid}};
        pat_b = {COLOR_BITS{tail.grid}};
      end
      default: ;
    endcase

    h_sync_d = tail.hs ? H_ON : ~H_ON;
    v_sync_d = tail.vs ? V_ON : ~V_ON;
    de_d     = tail.active;
    fs_d     = tail.first;
    r_d      = tail.active ? pat_r : '0;
    g_d      = tail.active ? pat_g : '0;
    b_d      = tail.active ? pat_b : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_sync_q <= ~H_ON;
      v_sync_q <= ~V_ON;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign h_sync         = h_sync_q;
  assign v_sync         = v_sync_q;
  assign drawing_pixels = de_q;
  assign frame_start    = fs_q;
  assign r              = r_q;
  assign g              = g_q;
  assign b              = b_q;

endmodule

// File: tb/tb_vga_stream_core.sv
// Bench for vga_stream_core with a reduced raster (58x44 total, 42x36 active,
// 42 not a multiple of 8) and FETCH_LAT=3. A scoreboard holds the expected
// pins for every counter value; a fetch model returns
// {h[3:0], v[3:0], 4'h5} three cycles after each pointer.

module tb_vga_stream_core;

  localparam int HA = 42, HF = 4, HS = 6, HB = 6;
  localparam int VA = 36, VF = 2, VS = 3, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HP = 1, VP = 0, CB = 4, FL = 3;
  localparam int BW = HA / 8;
  localparam logic H_ON = (HP != 0);
  localparam logic V_ON = (VP != 0);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] pixstream = 12'd0;
  logic [10:0] hread_ptr, vread_ptr;
  logic        read_en, h_sync, v_sync, drawing_pixels, frame_start;
  logic [3:0]  r, g, b;

  always #5 clk = ~clk;

  vga_stream_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .COLOR_BITS(CB), .FETCH_LAT(FL)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .pixstream(pixstream),
    .hread_ptr(hread_ptr), .vread_ptr(vread_ptr), .read_en(read_en),
    .h_sync(h_sync), .v_sync(v_sync), .r(r), .g(g), .b(b),
    .drawing_pixels(drawing_pixels), .frame_start(frame_start)
  );

  typedef struct packed {
    logic        valid;
    logic [1:0]  m;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, de, fs;
    logic [3:0]  r, g, b;
  } exp_t;

  typedef struct packed {
    logic [1:0]  m;
    logic [10:0] h;
    logic [10:0] v;
    logic        de;
    logic [3:0]  r, g, b;
  } vec_t;

  exp_t        sb[$];
  exp_t        last;
  logic [21:0] ptr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          h_m = 0, v_m = 0;
  logic [1:0]  fm_m = 2'd0;
  int          hs_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  function automatic exp_t idle();
    exp_t e;
    e    = '0;
    e.hs = ~H_ON;
    e.vs = ~V_ON;
    return e;
  endfunction

  function automatic exp_t model(input int h, input int v, input logic [1:0] m);
    exp_t e;
    int   i, c;
    e       = '0;
    e.valid = 1'b1;
    e.m     = m;
    e.h     = 11'(h);
    e.v     = 11'(v);
    e.hs    = (h >= HA + HF && h < HA + HF + HS) ? H_ON : ~H_ON;
    e.vs    = (v >= VA + VF && v < VA + VF + VS) ? V_ON : ~V_ON;
    e.de    = (h < HA && v < VA);
    e.fs    = (h == 0 && v == 0);
    if (e.de) begin
      case (m)
        2'd0: begin e.r = 4'(h); e.g = 4'(v); e.b = 4'h5; end
        2'd1: begin
          i = h / BW;
          if (i > 7) i = 7;
          c = 7 - i;
          e.r = ((c & 4) != 0) ? 4'hF : 4'h0;
          e.g = ((c & 2) != 0) ? 4'hF : 4'h0;
          e.b = ((c & 1) != 0) ? 4'hF : 4'h0;
        end
        2'd2: if (h % 32 == 0 || v % 32 == 0) begin e.r = 4'hF; e.g = 4'hF; e.b = 4'hF; end
        default: ;
      endcase
    end
    return e;
  endfunction

  // One clock: queue the expectation for the current counter value (inputs
  // are final by now), advance the model across the edge, compare the pins
  // and feed the fetch model.
  task automatic cycle();
    exp_t        e;
    logic        rst_s;
    logic [21:0] p;
    if (h_m == 0 && v_m == 0) fm_m = mode;
    sb.push_back(model(h_m, v_m, fm_m));
    rst_s = reset;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      h_m  = 0;
      v_m  = 0;
      fm_m = 2'd0;
      sb.delete();
      for (int i = 0; i < FL + 1; i++) sb.push_back(idle());
    end else begin
      h_m++;
      if (h_m == HT) begin
        h_m = 0;
        v_m = (v_m == VT - 1) ? 0 : v_m + 1;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      e = idle();
    end else begin
      e = sb.pop_front();
    end
    last = e;
    chk("pins", 64'({h_sync, v_sync, drawing_pixels, frame_start, r, g, b}),
        64'({e.hs, e.vs, e.de, e.fs, e.r, e.g, e.b}));
    chk("ptr", 64'({read_en, hread_ptr, vread_ptr}),
        64'({(h_m < HA && v_m < VA), 11'(h_m), 11'(v_m)}));
    if (h_sync == H_ON) hs_run++;
    else begin
      if (hs_run > 0) chk("hs_pulse_max", 64'(hs_run > HS), 64'(0));
      hs_run = 0;
    end
    ptr_q.push_back({hread_ptr, vread_ptr});
    if (ptr_q.size() > FL) begin
      p = ptr_q.pop_front();
      pixstream = {p[14:11], p[3:0], 4'h5};
    end
  endtask

  function automatic vec_t mk(input int m, input int h, input int v, input int de,
                              input int rr, input int gg, input int bb);
    vec_t t;
    t.m  = 2'(m);
    t.h  = 11'(h);
    t.v  = 11'(v);
    t.de = 1'(de);
    t.r  = 4'(rr);
    t.g  = 4'(gg);
    t.b  = 4'(bb);
    return t;
  endfunction

  initial begin
    vec_t tbl[16];
    int   n, t_de, t_hs1, t_hf, t_hs2, t_f1, t_f2, de_cnt, de_rise, vs_run, vs_w;
    logic found, prev_de, prev_hs, hs_act, vs_act, hit;

    // Hand-derived pixels, in raster order within each mode (BAR_W = 5).
    tbl[0]  = mk(0,  0,  0, 1, 4'h0, 4'h0, 4'h5);
    tbl[1]  = mk(0, 42,  0, 0, 4'h0, 4'h0, 4'h0);
    tbl[2]  = mk(0, 13,  7, 1, 4'hD, 4'h7, 4'h5);
    tbl[3]  = mk(0, 41, 35, 1, 4'h9, 4'h3, 4'h5);
    tbl[4]  = mk(1,  0,  0, 1, 4'hF, 4'hF, 4'hF);
    tbl[5]  = mk(1,  5,  1, 1, 4'hF, 4'hF, 4'h0);
    tbl[6]  = mk(1, 12,  1, 1, 4'hF, 4'h0, 4'hF);
    tbl[7]  = mk(1, 39,  2, 1, 4'h0, 4'h0, 4'h0);
    tbl[8]  = mk(1, 34,  3, 1, 4'h0, 4'h0, 4'hF);
    tbl[9]  = mk(1, 41,  3, 1, 4'h0, 4'h0, 4'h0);
    tbl[10] = mk(1, 20,  4, 1, 4'h0, 4'hF, 4'hF);
    tbl[11] = mk(2,  5,  5, 1, 4'h0, 4'h0, 4'h0);
    tbl[12] = mk(2, 32,  5, 1, 4'hF, 4'hF, 4'hF);
    tbl[13] = mk(2,  0, 10, 1, 4'hF, 4'hF, 4'hF);
    tbl[14] = mk(2,  5, 32, 1, 4'hF, 4'hF, 4'hF);
    tbl[15] = mk(3, 10, 10, 1, 4'h0, 4'h0, 4'h0);

    // Reset held for 5 cycles.
    reset = 1'b0;
    mode  = 2'd0;
    repeat (5) cycle();
    chk("rst_sync", 64'({h_sync, v_sync}), 64'({~H_ON, ~V_ON}));
    chk("rst_rgb_de", 64'({r, g, b, drawing_pixels, frame_start}), 64'(0));
    chk("rst_ptr", 64'({hread_ptr, vread_ptr, read_en}), 64'(1));

    // frame_start arrives FETCH_LAT+1 cycles after release.
    reset = 1'b1;
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      n++;
      if (frame_start) found = 1'b1;
    end
    chk("fs_latency", 64'(n), 64'(FL + 1));

    // Horizontal timing on the next full line.
    t_de = -1; t_hs1 = -1; t_hf = -1; t_hs2 = -1;
    prev_de = 1'b1; prev_hs = 1'b1;
    for (int k = 0; k < 3 * HT && t_hs2 < 0; k++) begin
      cycle();
      hs_act = (h_sync == H_ON);
      if (t_de < 0 && drawing_pixels && !prev_de) t_de = k;
      else if (t_de >= 0 && t_hs1 < 0 && hs_act && !prev_hs) t_hs1 = k;
      else if (t_hs1 >= 0 && t_hf < 0 && !hs_act) t_hf = k;
      else if (t_hf >= 0 && t_hs2 < 0 && hs_act && !prev_hs) t_hs2 = k;
      prev_de = drawing_pixels;
      prev_hs = hs_act;
    end
    chk("de_to_hsync", 64'(t_hs1 - t_de), 64'(HA + HF));
    chk("hsync_width", 64'(t_hf - t_hs1), 64'(HS));
    chk("line_period", 64'(t_hs2 - t_hs1), 64'(HT));

    // Vertical timing over one whole frame.
    t_f1 = -1; t_f2 = -1; de_cnt = 0; de_rise = 0; vs_run = 0; vs_w = -1;
    prev_de = 1'b0;
    for (int k = 0; k < 2 * HT * VT + 10 && t_f2 < 0; k++) begin
      cycle();
      if (frame_start) begin
        if (t_f1 < 0) t_f1 = k;
        else t_f2 = k;
      end
      if (t_f1 >= 0 && t_f2 < 0) begin
        if (drawing_pixels) de_cnt++;
        if (drawing_pixels && !prev_de) de_rise++;
      end
      vs_act = (v_sync == V_ON);
      if (vs_act) vs_run++;
      else begin
        if (vs_run > 0 && vs_w < 0) vs_w = vs_run;
        vs_run = 0;
      end
      prev_de = drawing_pixels;
    end
    chk("frame_period", 64'(t_f2 - t_f1), 64'(HT * VT));
    chk("vsync_width", 64'(vs_w), 64'(VS * HT));
    chk("enabled_pixels", 64'(de_cnt), 64'(HA * VA));
    chk("enabled_lines", 64'(de_rise), 64'(VA));

    // Table of pattern pixels; switching mode mid-frame must not tear.
    for (int i = 0; i < 16; i++) begin
      mode = tbl[i].m;
      hit  = 1'b0;
      for (int k = 0; k < 3 * HT * VT && !hit; k++) begin
        cycle();
        if (last.valid && last.m == tbl[i].m && last.h == tbl[i].h && last.v == tbl[i].v)
          hit = 1'b1;
      end
      if (!hit) begin
        checks++; errors++;
        $display("FAIL vec%0d_timeout actual=none required=pixel(%0d,%0d)", i, tbl[i].h, tbl[i].v);
      end else begin
        chk($sformatf("vec%0d", i), 64'({drawing_pixels, r, g, b}),
            64'({tbl[i].de, tbl[i].r, tbl[i].g, tbl[i].b}));
      end
    end

    // Mid-frame reset at (21,18), then again in the middle of an h_sync pulse.
    mode = 2'd0;
    for (int rep = 0; rep < 2; rep++) begin
      hit = 1'b0;
      for (int k = 0; k < 2 * HT * VT && !hit; k++) begin
        if ((rep == 0 && h_m == HA / 2 && v_m == VA / 2) ||
            (rep == 1 && h_m == HA + HF + 2 && v_m == 5)) hit = 1'b1;
        else cycle();
      end
      reset = 1'b0;
      cycle();
      chk($sformatf("midreset%0d_ptr", rep), 64'({hread_ptr, vread_ptr}), 64'(0));
      reset = 1'b1;
      repeat (HT * VT + 2 * HT) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
